// File: rtl/morse_decoder_if.sv
// rtl/morse_decoder_if.sv - symbol-in / character-out handshake bundle for morse_decoder
interface morse_decoder_if;
    logic [7:0] sym_in;
    logic       sym_valid;
    logic       sym_ready;
    logic [7:0] char_out;
    logic       char_valid;
    logic       char_ready;
    logic       error;

    // master: symbol source plus character sink; slave: the decoder itself
    modport master (
        output sym_in, sym_valid, char_ready,
        input  sym_ready, char_out, char_valid, error
    );

    modport slave (
        input  sym_in, sym_valid, char_ready,
        output sym_ready, char_out, char_valid, error
    );
endinterface

// File: rtl/morse_decoder.sv
// rtl/morse_decoder.sv - streaming Morse symbol to ASCII decoder (optional prosigns: MORSE_DECODER_PROSIGN_EN)
module morse_decoder #(
    parameter logic [7:0] ERR_CHAR = 8'h3F
) (
    input  logic           Clk,
    input  logic           Reset,
    morse_decoder_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        EMIT    = 2'd2
    } state_t;

    localparam logic [7:0] SYM_DOT  = 8'h2E;
    localparam logic [7:0] SYM_DASH = 8'h2D;
    localparam logic [7:0] SYM_SEP  = 8'h20;

    state_t     state_q, state_d;
    logic [2:0] len_q, len_d;
    logic [4:0] pat_q, pat_d;
    logic       bad_q, bad_d;
    logic [7:0] char_q, char_d;
    logic       err_q, err_d;
    logic       valid_q, valid_d;
    logic       sym_fire;
    logic [8:0] lut;

    // Returns {error, char}; pattern bits above len are always zero.
    function automatic logic [8:0] lookup(input logic [2:0] len, input logic [4:0] pat,
                                          input logic bad);
        logic [7:0] c;
        c = 8'h00;
        case ({len, pat})
            {3'd1, 5'b00000}: c = 8'h45; // E
            {3'd1, 5'b00001}: c = 8'h54; // T
            {3'd2, 5'b00000}: c = 8'h49; // I
            {3'd2, 5'b00001}: c = 8'h41; // A
            {3'd2, 5'b00010}: c = 8'h4E; // N
            {3'd2, 5'b00011}: c = 8'h4D; // M
            {3'd3, 5'b00000}: c = 8'h53; // S
            {3'd3, 5'b00001}: c = 8'h55; // U
            {3'd3, 5'b00010}: c = 8'h52; // R
            {3'd3, 5'b00011}: c = 8'h57; // W
            {3'd3, 5'b00100}: c = 8'h44; // D
            {3'd3, 5'b00101}: c = 8'h4B; // K
            {3'd3, 5'b00110}: c = 8'h47; // G
            {3'd3, 5'b00111}: c = 8'h4F; // O
            {3'd4, 5'b00000}: c = 8'h48; // H
            {3'd4, 5'b00001}: c = 8'h56; // V
            {3'd4, 5'b00010}: c = 8'h46; // F
            {3'd4, 5'b00100}: c = 8'h4C; // L
            {3'd4, 5'b00110}: c = 8'h50; // P
            {3'd4, 5'b00111}: c = 8'h4A; // J
            {3'd4, 5'b01000}: c = 8'h42; // B
            {3'd4, 5'b01001}: c = 8'h58; // X
            {3'd4, 5'b01010}: c = 8'h43; // C
            {3'd4, 5'b01011}: c = 8'h59; // Y
            {3'd4, 5'b01100}: c = 8'h5A; // Z
            {3'd4, 5'b01101}: c = 8'h51; // Q
            {3'd5, 5'b11111}: c = 8'h30;
            {3'd5, 5'b01111}: c = 8'h31;
            {3'd5, 5'b00111}: c = 8'h32;
            {3'd5, 5'b00011}: c = 8'h33;
            {3'd5, 5'b00001}: c = 8'h34;
            {3'd5, 5'b00000}: c = 8'h35;
            {3'd5, 5'b10000}: c = 8'h36;
            {3'd5, 5'b11000}: c = 8'h37;
            {3'd5, 5'b11100}: c = 8'h38;
            {3'd5, 5'b11110}: c = 8'h39;
`ifdef MORSE_DECODER_PROSIGN_EN
            {3'd5, 5'b10001}: c = 8'h3D;
            {3'd5, 5'b10010}: c = 8'h2F;
            {3'd5, 5'b01010}: c = 8'h2B;
`endif
            default:          c = 8'h00;
        endcase
        if (bad || c == 8'h00) begin
            lookup = {1'b1, ERR_CHAR};
        end else begin
            lookup = {1'b0, c};
        end
    endfunction

    assign sym_fire = bus.sym_valid && (state_q != EMIT);
    assign lut      = lookup(len_q, pat_q, bad_q);

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        pat_d   = pat_q;
        bad_d   = bad_q;
        char_d  = char_q;
        err_d   = err_q;
        valid_d = valid_q;
        case (state_q)
            IDLE, COLLECT: begin
                if (sym_fire) begin
                    if (bus.sym_in == SYM_DOT || bus.sym_in == SYM_DASH) begin
                        if (len_q < 3'd5) begin
                            pat_d = {pat_q[3:0], (bus.sym_in == SYM_DASH)};
                            len_d = 3'(len_q + 3'd1);
                        end else begin
                            bad_d = 1'b1;
                        end
                        state_d = COLLECT;
                    end else if (bus.sym_in == SYM_SEP) begin
                        // A separator with nothing collected is a word gap: ignore it.
                        if (state_q == COLLECT) begin
                            char_d  = lut[7:0];
                            err_d   = lut[8];
                            valid_d = 1'b1;
                            len_d   = 3'd0;
                            pat_d   = 5'd0;
                            bad_d   = 1'b0;
                            state_d = EMIT;
                        end
                    end else begin
                        bad_d   = 1'b1;
                        state_d = COLLECT;
                    end
                end
            end
            EMIT: begin
                if (bus.char_ready) begin
                    valid_d = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= IDLE;
            len_q   <= 3'd0;
            pat_q   <= 5'd0;
            bad_q   <= 1'b0;
            char_q  <= 8'h00;
            err_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            pat_q   <= pat_d;
            bad_q   <= bad_d;
            char_q  <= char_d;
            err_q   <= err_d;
            valid_q <= valid_d;
        end
    end

    assign bus.sym_ready  = (state_q != EMIT);
    assign bus.char_out   = char_q;
    assign bus.char_valid = valid_q;
    assign bus.error      = err_q;
endmodule

// File: tb/tb_morse_decoder.sv
// tb/tb_morse_decoder.sv - randomized self-checking bench for morse_decoder against a string-table model
module tb_morse_decoder;
    localparam logic [7:0] ERR = 8'h3F;

    logic Clk = 1'b0;
    logic Reset = 1'b1;
    morse_decoder_if ifc();

    morse_decoder dut (.Clk(Clk), .Reset(Reset), .bus(ifc));

    always #5 Clk = ~Clk;

    int pass_cnt = 0;
    int total = 0;
    int viol = 0;
    bit rand_bp = 1'b0;
    logic [8:0] q[$];
    logic [7:0] tbl[string];

    bit pv = 1'b0;
    bit ph = 1'b0;
    logic [8:0] pd = '0;

    // Record every character handshake and flag any output change while stalled.
    always @(negedge Clk) begin
        if (Reset) begin
            pv = 1'b0;
        end else begin
            if (pv && !ph && (!ifc.char_valid || {ifc.error, ifc.char_out} != pd)) viol++;
            if (ifc.char_valid && ifc.char_ready) q.push_back({ifc.error, ifc.char_out});
            pv = ifc.char_valid;
            ph = ifc.char_valid && ifc.char_ready;
            pd = {ifc.error, ifc.char_out};
        end
    end

    always @(posedge Clk) begin
        if (rand_bp) begin
            #1;
            ifc.char_ready = 1'($urandom_range(0, 1));
        end
    end

    function automatic logic [8:0] model(input string s);
        if (tbl.exists(s)) return {1'b0, tbl[s]};
        return {1'b1, ERR};
    endfunction

    task automatic send_sym(input logic [7:0] b);
        int n;
        n = 0;
        ifc.sym_in = b;
        ifc.sym_valid = 1'b1;
        @(negedge Clk);
        while (!ifc.sym_ready && n < 200) begin
            @(negedge Clk);
            n++;
        end
        if (n >= 200) begin
            total++;
            $display("FAIL sym_accept_timeout: sym_ready=%b, required 1 within 200 cycles", ifc.sym_ready);
        end
        @(posedge Clk); #1;
        ifc.sym_valid = 1'b0;
    endtask

    task automatic send_letter(input string s);
        for (int i = 0; i < s.len(); i++) send_sym(s[i]);
        send_sym(8'h20);
    endtask

    task automatic wait_chars(input int n);
        int k;
        k = 0;
        while (q.size() < n && k < 300) begin
            @(negedge Clk);
            k++;
        end
        total++;
        if (q.size() < n) $display("FAIL char_timeout: got %0d chars, required %0d", q.size(), n);
        else pass_cnt++;
        @(posedge Clk); #1;
    endtask

    task automatic test_reset;
        ifc.sym_in = 8'h00; ifc.sym_valid = 1'b0; ifc.char_ready = 1'b1;
        Reset = 1'b1;
        repeat (3) @(negedge Clk);
        total++;
        if ({ifc.sym_ready, ifc.char_valid, ifc.char_out, ifc.error} !== {1'b1, 1'b0, 8'h00, 1'b0})
            $display("FAIL reset_values: rdy=%b vld=%b chr=%h err=%b, required 1 0 00 0",
                     ifc.sym_ready, ifc.char_valid, ifc.char_out, ifc.error);
        else pass_cnt++;
        @(posedge Clk); #1;
        Reset = 1'b0;
        @(negedge Clk);
        total++;
        if ({ifc.sym_ready, ifc.char_valid} !== 2'b10)
            $display("FAIL post_reset_idle: rdy=%b vld=%b, required 1 0", ifc.sym_ready, ifc.char_valid);
        else pass_cnt++;
        @(posedge Clk); #1;
    endtask

    task automatic test_basic_latency;
        q.delete();
        send_sym(8'h2E);
        send_sym(8'h2D);
        ifc.sym_in = 8'h20; ifc.sym_valid = 1'b1;
        @(negedge Clk);
        @(posedge Clk); #1;
        ifc.sym_valid = 1'b0;
        @(negedge Clk);
        total++;
        if ({ifc.char_valid, ifc.sym_ready, ifc.error, ifc.char_out} !== {1'b1, 1'b0, 1'b0, 8'h41})
            $display("FAIL A_first_cycle: vld=%b rdy=%b err=%b chr=%h, required 1 0 0 41",
                     ifc.char_valid, ifc.sym_ready, ifc.error, ifc.char_out);
        else pass_cnt++;
        @(negedge Clk);
        total++;
        if ({ifc.char_valid, ifc.sym_ready} !== 2'b01)
            $display("FAIL A_one_cycle: vld=%b rdy=%b, required 0 1", ifc.char_valid, ifc.sym_ready);
        else pass_cnt++;
        total++;
        if (q.size() != 1) $display("FAIL A_count: got %0d chars, required 1", q.size());
        else pass_cnt++;
        @(posedge Clk); #1;
    endtask

    task automatic test_digits_letters;
        q.delete();
        send_letter("-----");
        send_letter("....");
        wait_chars(2);
        if (q.size() >= 2) begin
            total++;
            if (q[0] !== {1'b0, 8'h30}) $display("FAIL digit_0: got %h, required 030", q[0]);
            else pass_cnt++;
            total++;
            if (q[1] !== {1'b0, 8'h48}) $display("FAIL letter_H: got %h, required 048", q[1]);
            else pass_cnt++;
        end
    endtask

    task automatic test_gaps;
        q.delete();
        send_sym(8'h20);
        send_sym(8'h20);
        repeat (5) @(negedge Clk);
        total++;
        if (q.size() != 0 || ifc.char_valid !== 1'b0)
            $display("FAIL word_gap: got %0d chars vld=%b, required 0 chars vld=0", q.size(), ifc.char_valid);
        else pass_cnt++;
        @(posedge Clk); #1;
    endtask

    task automatic test_errors;
        string cases[3];
        cases = '{"......", "..--", ".x"};
        q.delete();
        foreach (cases[i]) send_letter(cases[i]);
        wait_chars(3);
        for (int i = 0; i < 3; i++) begin
            if (i < q.size()) begin
                total++;
                if (q[i] !== {1'b1, ERR})
                    $display("FAIL err_case_%0d: got %h, required %h", i, q[i], {1'b1, ERR});
                else pass_cnt++;
            end
        end
    endtask

    task automatic test_backpressure;
        q.delete();
        ifc.char_ready = 1'b0;
        send_letter("-");
        ifc.sym_in = 8'h2E; ifc.sym_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge Clk);
            total++;
            if ({ifc.char_valid, ifc.char_out, ifc.error, ifc.sym_ready} !== {1'b1, 8'h54, 1'b0, 1'b0})
                $display("FAIL T_held_%0d: vld=%b chr=%h err=%b rdy=%b, required 1 54 0 0",
                         i, ifc.char_valid, ifc.char_out, ifc.error, ifc.sym_ready);
            else pass_cnt++;
        end
        @(posedge Clk); #1;
        ifc.char_ready = 1'b1;
        @(negedge Clk);
        @(posedge Clk); #1;
        @(negedge Clk);
        total++;
        if ({ifc.char_valid, ifc.sym_ready} !== 2'b01)
            $display("FAIL T_release: vld=%b rdy=%b, required 0 1", ifc.char_valid, ifc.sym_ready);
        else pass_cnt++;
        @(posedge Clk); #1;
        ifc.sym_valid = 1'b0;
        send_sym(8'h20);
        wait_chars(2);
        if (q.size() >= 2) begin
            total++;
            if (q[0] !== {1'b0, 8'h54} || q[1] !== {1'b0, 8'h45})
                $display("FAIL T_then_E: got %h %h, required 054 045", q[0], q[1]);
            else pass_cnt++;
        end
    endtask

    task automatic test_prosign;
        logic [8:0] exp;
`ifdef MORSE_DECODER_PROSIGN_EN
        exp = {1'b0, 8'h3D};
`else
        exp = {1'b1, 8'h3F};
`endif
        q.delete();
        send_letter("-...-");
        wait_chars(1);
        if (q.size() >= 1) begin
            total++;
            if (q[0] !== exp) $display("FAIL prosign_eq: got %h, required %h", q[0], exp);
            else pass_cnt++;
        end
    endtask

    task automatic test_reset_midletter;
        q.delete();
        send_sym(8'h2D);
        send_sym(8'h2E);
        Reset = 1'b1;
        @(negedge Clk);
        total++;
        if ({ifc.sym_ready, ifc.char_valid, ifc.char_out, ifc.error} !== {1'b1, 1'b0, 8'h00, 1'b0})
            $display("FAIL midletter_reset: rdy=%b vld=%b chr=%h err=%b, required 1 0 00 0",
                     ifc.sym_ready, ifc.char_valid, ifc.char_out, ifc.error);
        else pass_cnt++;
        @(posedge Clk); #1;
        Reset = 1'b0;
        send_letter(".");
        wait_chars(1);
        repeat (5) @(negedge Clk);
        total++;
        if (q.size() != 1 || q[0] !== {1'b0, 8'h45})
            $display("FAIL after_reset_E: got %0d chars first=%h, required 1 chars 045", q.size(),
                     (q.size() > 0) ? q[0] : 9'h000);
        else pass_cnt++;
        @(posedge Clk); #1;
    endtask

    task automatic test_random;
        logic [8:0] exp_q[$];
        string s;
        int len, r, n;
        n = 40;
        q.delete();
        rand_bp = 1'b1;
        for (int i = 0; i < n; i++) begin
            s = "";
            len = $urandom_range(1, 6);
            for (int j = 0; j < len; j++) begin
                r = $urandom_range(0, 19);
                if (r == 0) s = $sformatf("%s%c", s, 8'h78);
                else if (r < 10) s = $sformatf("%s%c", s, 8'h2E);
                else s = $sformatf("%s%c", s, 8'h2D);
            end
            exp_q.push_back(model(s));
            send_letter(s);
        end
        wait_chars(n);
        rand_bp = 1'b0;
        @(posedge Clk); #2;
        ifc.char_ready = 1'b1;
        @(posedge Clk); #1;
        for (int i = 0; i < n; i++) begin
            if (i < q.size()) begin
                total++;
                if (q[i] !== exp_q[i]) $display("FAIL rand_%0d: got %h, required %h", i, q[i], exp_q[i]);
                else pass_cnt++;
            end
        end
        total++;
        if (viol != 0) $display("FAIL output_stability: %0d violations, required 0", viol);
        else pass_cnt++;
    endtask

    initial begin
        string letters[26];
        string digits[10];
        letters = '{".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....", "..", ".---",
                    "-.-", ".-..", "--", "-.", "---", ".--.", "--.-", ".-.", "...", "-",
                    "..-", "...-", ".--", "-..-", "-.--", "--.."};
        digits = '{"-----", ".----", "..---", "...--", "....-", ".....", "-....", "--...",
                   "---..", "----."};
        foreach (letters[i]) tbl[letters[i]] = 8'(8'h41 + i);
        foreach (digits[i]) tbl[digits[i]] = 8'(8'h30 + i);
`ifdef MORSE_DECODER_PROSIGN_EN
        tbl["-...-"] = 8'h3D;
        tbl["-..-."] = 8'h2F;
        tbl[".-.-."] = 8'h2B;
`endif
        test_reset();
        test_basic_latency();
        test_digits_letters();
        test_gaps();
        test_errors();
        test_backpressure();
        test_prosign();
        test_reset_midletter();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule
